contador_monitor: RTL and testbench
===================================

# contador_monitor

Synthesizable response-side monitor for the 4-bit mode counter. It observes the counter's stimulus (enable, mode, D) and its response (Q, rco, load) and predicts every response cycle from the previous stimulus. It flags and counts mismatches and counts wrap-arounds. It sits beside the counter in the timing and gate-level benches and in FPGA builds, as the hardware counterpart of the behavioural scoreboard.

## Interface
Parameters:
- CNT_W, 8, width of the saturating err_count and wrap_count counters.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high; same net that resets the counter.
- enable  in  1  counter enable as driven to the counter.
- mode  in  2  counter mode as driven to the counter.
- D  in  4  counter parallel-load data.
- Q  in  4  counter output value.
- rco  in  1  counter ripple-carry-out.
- load  in  1  counter load indicator.
- err  out  1  one-cycle pulse on any mismatch.
- err_code  out  3  mismatch bits for the current cycle: [0] Q, [1] rco, [2] load; 0 when err is 0.
- err_sticky  out  1  set on first mismatch; held until reset.
- err_count  out  CNT_W  mismatching cycles, saturating.
- wrap_count  out  CNT_W  observed rco pulses that matched prediction, saturating.
- tracking  out  1  1 when in TRACK state.

## Operation
- Counter reference model. The counter registers all outputs on the clock edge after the stimulus cycle. With enable=0: Q holds, rco=0, load=0. With enable=1, the mode selects the behaviour:
  - 00: Q+3 mod 16; rco=1 iff Q+3 > 15.
  - 01: Q-1 mod 16; rco=1 iff Q==0.
  - 10: Q+1 mod 16; rco=1 iff Q==15.
  - 11: Q=D, rco=0, load=1.
  - load=0 in every mode other than 11.
- Prediction arithmetic uses a 5-bit sum. rco is taken from bit 4 for mode 00, and from the explicit compares above for modes 01 and 10.
- State machine:
  - SYNC, the reset state. Captures Q, enable, mode and D, and checks nothing. Moves to TRACK on the next clock.
  - TRACK. Each cycle compares the observed {Q, rco, load} with the prediction built from the previous cycle's registered Q, enable, mode and D. It then registers the current Q as the base for the next prediction.
  - Resync on mismatch: the next prediction always uses the observed Q, never the predicted Q. A single fault therefore produces exactly one err pulse.
- Counters:
  - err_count increments on each cycle with err=1.
  - wrap_count increments when rco=1 and bit [1] of err_code is 0.
  - Both stop at 2^CNT_W-1.
- Reset asserted in any state:
  - Next state is SYNC.
  - err, err_code, err_sticky, err_count, wrap_count and tracking all go to 0.
  - Any prediction in flight is discarded.

## Timing
- Detection latency: the err pulse is registered and appears 1 clock after the mismatching Q/rco/load sample, which is 2 clocks after the causing stimulus.
- The first check occurs on the 2nd rising edge after reset deasserts; tracking rises on the 1st.
- Simultaneous rco mismatch and Q mismatch: both bits are set in err_code, and err_count increments once.
- Mode or enable changes take effect in the prediction for the next response cycle only, with no extra pipeline.
- Wrap cases with enable=1:
  - Q=15, mode 10: predicts 0 with rco=1.
  - Q=14, mode 00: predicts 1 with rco=1.
  - Q=0, mode 01: predicts 15 with rco=1.

## Configuration
- CONTADOR_MON_SNAP_EN. When defined, adds three outputs:
  - snap_exp (4), the expected Q at the first mismatch.
  - snap_act (4), the actual Q at the first mismatch.
  - snap_mode (2), the mode that produced the first mismatch.
- The snapshot is loaded when err_sticky rises, is frozen until reset, and is 0 after reset.
- When undefined, these ports and registers do not exist. The remaining behaviour is identical.

## Test plan
- Reset, then hold enable=1 and mode=10 with a correct counter for 20 cycles -> err never 1; wrap_count=1 at Q=15->0; err_count=0.
- Mode 00 starting at Q=0 for 6 cycles -> expect Q sequence 3, 6, 9, 12, 15, 2 with rco=1 only on 2; wrap_count=1.
- Mode 11 with D=4'hA -> Q=A and load=1 one cycle later, no err. Then force load=0 on that cycle -> err=1, err_code=3'b100, err_sticky=1.
- Force Q to 5 instead of 4 once in mode 01 -> exactly one err pulse with err_code=3'b001. The next cycle expects 4 (resync from 5), with no further err.
- Assert reset mid-TRACK after 3 errors -> next cycle all outputs 0, tracking=0; tracking=1 one cycle after release.
- With CONTADOR_MON_SNAP_EN defined, first error at expected 7 / actual 8 in mode 10 -> snap_exp=7, snap_act=8, snap_mode=2'b10, unchanged by later errors.

Source files
------------

// File: rtl/contador_monitor.sv
// ---------------------------------------------------------------------------
// contador_monitor
//
// Response-side monitor for the 4-bit mode counter. It watches the stimulus
// the counter receives (enable, mode, D) and the response it produces
// (Q, rco, load). Every response cycle is predicted from the previous cycle's
// stimulus and observed Q. Mismatches are flagged and counted, and correctly
// predicted wrap-arounds (rco pulses) are counted.
//
// Optional feature macro: CONTADOR_MON_SNAP_EN
//   When defined, snap_exp / snap_act / snap_mode capture the expected Q,
//   the actual Q and the causing mode of the first mismatch after reset.
//
// Parameters
//   CNT_W       width of the saturating err_count / wrap_count counters
//
// Ports
//   clk         single rising-edge clock
//   reset       synchronous, active-high; same net that resets the counter
//   enable      counter enable as driven to the counter
//   mode        counter mode as driven to the counter
//   D           counter parallel-load data
//   Q           counter output value
//   rco         counter ripple-carry-out
//   load        counter load indicator
//   err         one-cycle pulse on any mismatch (registered)
//   err_code    mismatch bits of that cycle: [0] Q, [1] rco, [2] load
//   err_sticky  set on first mismatch, held until reset
//   err_count   number of mismatching cycles, saturating
//   wrap_count  number of observed rco pulses that matched the prediction
//   tracking    1 while the monitor is in the TRACK state
//   snap_exp    (optional) expected Q at first mismatch
//   snap_act    (optional) actual Q at first mismatch
//   snap_mode   (optional) mode that produced the first mismatch
//
// Handshake: there is no valid/ready handshake; every clock cycle carries one
// stimulus sample and one response sample, both unconditionally accepted.
// ---------------------------------------------------------------------------
module contador_monitor #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [3:0]       D,
  input  logic [3:0]       Q,
  input  logic             rco,
  input  logic             load,
  output logic             err,
  output logic [2:0]       err_code,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] wrap_count,
  output logic             tracking
`ifdef CONTADOR_MON_SNAP_EN
  ,
  output logic [3:0]       snap_exp,
  output logic [3:0]       snap_act,
  output logic [1:0]       snap_mode
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } state_t;

  state_t state, state_next;

  // Previous-cycle samples that form the base of the next prediction.
  logic [3:0] base_q;
  logic       base_en;
  logic [1:0] base_mode;
  logic [3:0] base_d;

  // Prediction of the current response.
  logic [4:0] sum5;
  logic [4:0] addend;
  logic [3:0] pred_q;
  logic       pred_rco;
  logic       pred_load;

  logic       check_en;
  logic [2:0] mis;
  logic       any_mis;
  logic       wrap_hit;

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SYNC;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state. SYNC only lasts one cycle, used to take the first
  // sample; once tracking, only reset leaves TRACK.
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      SYNC:    state_next = TRACK;
      TRACK:   state_next = TRACK;
      default: state_next = SYNC;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs. Checking happens only in TRACK, where the base registers
  // hold a genuine previous sample.
  // ---------------------------------------------------------------------
  always_comb begin
    tracking = 1'b0;
    check_en = 1'b0;
    if (state == TRACK) begin
      tracking = 1'b1;
      check_en = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Base sample capture. The observed Q (never the predicted Q) becomes the
  // next base, so a single faulty response causes exactly one err pulse.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      base_q    <= 4'd0;
      base_en   <= 1'b0;
      base_mode <= 2'b00;
      base_d    <= 4'd0;
    end else begin
      base_q    <= Q;
      base_en   <= enable;
      base_mode <= mode;
      base_d    <= D;
    end
  end

  // ---------------------------------------------------------------------
  // Reference model of the counter. All arithmetic goes through one 5-bit
  // sum; the down count adds 5'h1F, whose low nibble equals Q-1 mod 16.
  // Mode 00 takes rco from the carry bit; modes 01/10 use explicit compares.
  // ---------------------------------------------------------------------
  always_comb begin
    addend = 5'd0;
    case (base_mode)
      2'b00:   addend = 5'd3;
      2'b01:   addend = 5'h1F;
      2'b10:   addend = 5'd1;
      default: addend = 5'd0;
    endcase
  end

  assign sum5 = {1'b0, base_q} + addend;

  always_comb begin
    pred_q    = base_q;
    pred_rco  = 1'b0;
    pred_load = 1'b0;
    if (base_en) begin
      case (base_mode)
        2'b00: begin
          pred_q   = sum5[3:0];
          pred_rco = sum5[4];
        end
        2'b01: begin
          pred_q   = sum5[3:0];
          pred_rco = (base_q == 4'd0);
        end
        2'b10: begin
          pred_q   = sum5[3:0];
          pred_rco = (base_q == 4'd15);
        end
        default: begin
          pred_q    = base_d;
          pred_load = 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Compare observed response against the prediction.
  // ---------------------------------------------------------------------
  always_comb begin
    mis = 3'b000;
    if (check_en) begin
      mis[0] = (Q    != pred_q);
      mis[1] = (rco  != pred_rco);
      mis[2] = (load != pred_load);
    end
  end

  assign any_mis  = |mis;
  // A wrap counts only when the observed rco pulse was itself predicted.
  assign wrap_hit = check_en && rco && !mis[1];

  // ---------------------------------------------------------------------
  // Registered error reporting and saturating counters.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      err        <= 1'b0;
      err_code   <= 3'b000;
      err_sticky <= 1'b0;
      err_count  <= '0;
      wrap_count <= '0;
    end else begin
      err        <= any_mis;
      err_code   <= mis;
      err_sticky <= err_sticky | any_mis;
      if (any_mis && (err_count != CNT_MAX)) begin
        err_count <= err_count + CNT_ONE;
      end
      if (wrap_hit && (wrap_count != CNT_MAX)) begin
        wrap_count <= wrap_count + CNT_ONE;
      end
    end
  end

`ifdef CONTADOR_MON_SNAP_EN
  // ---------------------------------------------------------------------
  // First-mismatch snapshot: loaded on the same edge err_sticky rises and
  // frozen afterwards. The causing mode is the base mode, i.e. the mode
  // that was driven one cycle before the faulty response.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_exp  <= 4'd0;
      snap_act  <= 4'd0;
      snap_mode <= 2'b00;
    end else if (any_mis && !err_sticky) begin
      snap_exp  <= pred_q;
      snap_act  <= Q;
      snap_mode <= base_mode;
    end
  end
`endif

endmodule

// File: tb/tb_contador_monitor.sv
module tb_contador_monitor;

  localparam int CNT_W = 8;

  // -------------------------------------------------------------------------
  // Clock / reset and DUT
  // -------------------------------------------------------------------------
  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [1:0]       mode;
  logic [3:0]       D;
  logic [3:0]       Q;
  logic             rco;
  logic             load;
  logic             err;
  logic [2:0]       err_code;
  logic             err_sticky;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] wrap_count;
  logic             tracking;
`ifdef CONTADOR_MON_SNAP_EN
  logic [3:0]       snap_exp;
  logic [3:0]       snap_act;
  logic [1:0]       snap_mode;
`endif

  always #5 clk = ~clk;

  contador_monitor #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .mode       (mode),
    .D          (D),
    .Q          (Q),
    .rco        (rco),
    .load       (load),
    .err        (err),
    .err_code   (err_code),
    .err_sticky (err_sticky),
    .err_count  (err_count),
    .wrap_count (wrap_count),
    .tracking   (tracking)
`ifdef CONTADOR_MON_SNAP_EN
    ,
    .snap_exp   (snap_exp),
    .snap_act   (snap_act),
    .snap_mode  (snap_mode)
`endif
  );

  // -------------------------------------------------------------------------
  // Scoreboard: entry = {wrap_expected, err_code_expected[2:0]}
  // -------------------------------------------------------------------------
  logic [3:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         exp_err_cnt;
  int         exp_wrap;
  logic       exp_sticky;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  // Reset for one edge, check the cleared outputs, then release with the
  // counter showing its reset value and the given stimulus applied.
  task automatic do_reset(input logic en_i, input logic [1:0] mode_i, input logic [3:0] d_i);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_err",        err,        0);
    check("rst_err_code",   err_code,   0);
    check("rst_err_sticky", err_sticky, 0);
    check("rst_err_count",  err_count,  0);
    check("rst_wrap_count", wrap_count, 0);
    check("rst_tracking",   tracking,   0);
`ifdef CONTADOR_MON_SNAP_EN
    check("rst_snap_exp",   snap_exp,   0);
    check("rst_snap_act",   snap_act,   0);
    check("rst_snap_mode",  snap_mode,  0);
`endif
    reset       = 1'b0;
    Q           = 4'd0;
    rco         = 1'b0;
    load        = 1'b0;
    enable      = en_i;
    mode        = mode_i;
    D           = d_i;
    exp_q.delete();
    exp_err_cnt = 0;
    exp_wrap    = 0;
    exp_sticky  = 1'b0;
  endtask

  // One counter cycle: check the monitor's verdict on the previous response,
  // drive the counter's next response (optionally corrupted), then apply the
  // next stimulus.
  task automatic cycle(input logic en_i, input logic [1:0] mode_i, input logic [3:0] d_i,
                       input logic [3:0] q_xor, input logic rco_flip, input logic load_flip);
    logic [3:0] entry;
    logic [3:0] nq;
    logic       nrco;
    logic       nload;
    int         v;
    @(negedge clk);
    check("tracking", tracking, 1);
    if (exp_q.size() > 0) begin
      entry = exp_q.pop_front();
      if (entry[2:0] != 3'b000) begin
        if (exp_err_cnt < 255) exp_err_cnt++;
        exp_sticky = 1'b1;
      end
      if (entry[3] && exp_wrap < 255) exp_wrap++;
      check("err",        err,        (entry[2:0] != 3'b000));
      check("err_code",   err_code,   entry[2:0]);
      check("err_sticky", err_sticky, exp_sticky);
      check("err_count",  err_count,  exp_err_cnt);
      check("wrap_count", wrap_count, exp_wrap);
    end
    // Behavioural counter
    nq    = Q;
    nrco  = 1'b0;
    nload = 1'b0;
    if (enable) begin
      case (mode)
        2'b00: begin
          v    = int'(Q) + 3;
          nq   = v[3:0];
          nrco = (v > 15);
        end
        2'b01: begin
          nq   = (Q == 4'd0) ? 4'd15 : Q - 4'd1;
          nrco = (Q == 4'd0);
        end
        2'b10: begin
          nq   = (Q == 4'd15) ? 4'd0 : Q + 4'd1;
          nrco = (Q == 4'd15);
        end
        default: begin
          nq    = D;
          nload = 1'b1;
        end
      endcase
    end
    Q    = nq ^ q_xor;
    rco  = nrco ^ rco_flip;
    load = nload ^ load_flip;
    exp_q.push_back({nrco & ~rco_flip, load_flip, rco_flip, (q_xor != 4'd0)});
    enable = en_i;
    mode   = mode_i;
    D      = d_i;
  endtask

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    mode   = 2'b00;
    D      = 4'd0;
    Q      = 4'd0;
    rco    = 1'b0;
    load   = 1'b0;
    exp_err_cnt = 0;
    exp_wrap    = 0;
    exp_sticky  = 1'b0;

    // Up count through the 15->0 wrap with a correct counter.
    do_reset(1'b1, 2'b10, 4'd0);
    repeat (20) cycle(1'b1, 2'b10, 4'd0, 4'd0, 1'b0, 1'b0);
    check("mode10_wrap_count", wrap_count, 1);
    check("mode10_err_count",  err_count,  0);

    // Step-by-3 from 0: 3,6,9,12,15,2(rco),5.
    do_reset(1'b1, 2'b00, 4'd0);
    repeat (7) cycle(1'b1, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0);
    check("mode00_wrap_count", wrap_count, 1);
    check("mode00_err_count",  err_count,  0);

    // Parallel load of A, correct then with load suppressed.
    cycle(1'b1, 2'b11, 4'hA, 4'd0, 1'b0, 1'b0);
    cycle(1'b1, 2'b11, 4'hA, 4'd0, 1'b0, 1'b0);
    cycle(1'b1, 2'b01, 4'd0, 4'd0, 1'b0, 1'b1);
    cycle(1'b1, 2'b01, 4'd0, 4'd0, 1'b0, 1'b0);
    check("load_err_code",   err_code,   3'b100);
    check("load_err_sticky", err_sticky, 1);

    // Count down 9,8,7,6,5 then show 5 instead of 4; next must be 4.
    repeat (4) cycle(1'b1, 2'b01, 4'd0, 4'd0, 1'b0, 1'b0);
    cycle(1'b1, 2'b01, 4'd0, 4'h1, 1'b0, 1'b0);
    cycle(1'b1, 2'b01, 4'd0, 4'd0, 1'b0, 1'b0);
    check("resync_err_code", err_code, 3'b001);
    cycle(1'b1, 2'b01, 4'd0, 4'd0, 1'b0, 1'b0);
    check("resync_no_err", err, 0);

    // Q and rco wrong together: one counted error, two code bits.
    cycle(1'b1, 2'b01, 4'd0, 4'h3, 1'b1, 1'b0);
    cycle(1'b1, 2'b01, 4'd0, 4'd0, 1'b0, 1'b0);
    check("dual_err_code",  err_code,  3'b011);
    check("dual_err_count", err_count, 3);

    // Reset mid-track, then first-mismatch snapshot (7 expected, 8 seen).
    do_reset(1'b1, 2'b10, 4'd0);
    repeat (6) cycle(1'b1, 2'b10, 4'd0, 4'd0, 1'b0, 1'b0);
    cycle(1'b1, 2'b10, 4'd0, 4'hF, 1'b0, 1'b0);
    cycle(1'b1, 2'b10, 4'd0, 4'd0, 1'b0, 1'b0);
    check("snap_err_code", err_code, 3'b001);
`ifdef CONTADOR_MON_SNAP_EN
    check("snap_exp",  snap_exp,  4'd7);
    check("snap_act",  snap_act,  4'd8);
    check("snap_mode", snap_mode, 2'b10);
`endif
    cycle(1'b1, 2'b10, 4'd0, 4'h2, 1'b0, 1'b0);
    cycle(1'b1, 2'b10, 4'd0, 4'd0, 1'b0, 1'b0);
    check("second_err_count", err_count, 2);
`ifdef CONTADOR_MON_SNAP_EN
    check("snap_exp_frozen",  snap_exp,  4'd7);
    check("snap_act_frozen",  snap_act,  4'd8);
    check("snap_mode_frozen", snap_mode, 2'b10);
`endif

    // Hold with enable low and drain the scoreboard.
    cycle(1'b0, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0);
    cycle(1'b0, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety bound in case the clock or a task stalls.
  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: observed no completion expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
